// File: rtl/dio_spi_master.sv
// dio_spi_master
// SPI initiator for the IO-controller link. One transaction is a command
// byte followed by `len` payload bytes, all framed by one `ss` low period.
// Bits go out MSB first on sdi and are sampled from sdo one at a time.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   start, cmd, len    transaction request; cmd/len latched when accepted
//   tx_data/valid      payload byte source; tx_ready pulses on consume
//   rx_data/valid      received byte, one pulse per byte (cmd byte included)
//   busy, done         transaction in flight / one-cycle end pulse
//   ss, sck, sdi, sdo  SPI pins (ss active low, sck idles low)
module dio_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int SS_GAP    = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           cmd,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 ss,
  output logic                 sck,
  output logic                 sdi,
  input  logic                 sdo
);

  localparam int CMAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOW, HIGH, LOAD, HOLD, GAP
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;       // cycle count inside the current phase
  logic [2:0]           bit_cnt;   // bit being sent, 7 down to 0
  logic [LEN_WIDTH-1:0] remain;    // payload bytes still to fetch
  logic [7:0]           tx_sh;     // tx_sh[7] is the bit on sdi
  logic [7:0]           rx_sh;
  logic                 div_end, gap_end, accept;

  assign div_end = (cnt == DIV_LAST);
  assign gap_end = (cnt == GAP_LAST);
  // busy is already low on the last GAP cycle, so a start there is taken.
  assign accept  = start && ((state == IDLE) || (state == GAP && gap_end));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: if (div_end) state_nxt = HIGH;
      LOW:   if (div_end) state_nxt = HIGH;
      HIGH:
        if (div_end) begin
          if (bit_cnt != 3'd0)   state_nxt = LOW;
          else if (remain == '0) state_nxt = HOLD;
          else                   state_nxt = LOAD;
        end
      LOAD:  if (tx_valid) state_nxt = LOW;
      HOLD:  if (div_end) state_nxt = GAP;
      GAP:   if (gap_end) state_nxt = accept ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: phase counter, bit/byte counters, shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_cnt <= 3'd7;
      remain  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
    end else begin
      // The LOAD cycle that consumes a byte is the first cycle of its low
      // phase, so LOW starts one count in to keep the phase at CLK_DIV.
      if (state_nxt != state)
        cnt <= (state == LOAD) ? CW'(1) : '0;
      else if (state != IDLE && state != LOAD)
        cnt <= cnt + CW'(1);

      if (accept) begin
        bit_cnt <= 3'd7;
        remain  <= len;
        tx_sh   <= cmd;
      end

      if (state == HIGH && div_end) begin
        bit_cnt <= bit_cnt - 3'd1;  // wraps 0 -> 7 at the byte boundary
        // After bit 0 the last bit is left on sdi until the next load.
        if (bit_cnt != 3'd0) tx_sh <= {tx_sh[6:0], 1'b0};
      end

      if (state == LOAD && tx_valid) begin
        remain <= remain - LEN_WIDTH'(1);
        tx_sh  <= tx_data;
      end

      if (state == HIGH && cnt == '0) begin
        rx_sh <= {rx_sh[6:0], sdo};
        if (bit_cnt == 3'd0) rx_data <= {rx_sh[6:0], sdo};
      end
    end
  end

  // Output logic
  always_comb begin
    ss       = 1'b1;
    sck      = 1'b0;
    sdi      = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    case (state)
      SETUP, LOW, HOLD: begin
        ss   = 1'b0;
        sdi  = tx_sh[7];
        busy = 1'b1;
      end
      HIGH: begin
        ss       = 1'b0;
        sck      = 1'b1;
        sdi      = tx_sh[7];
        busy     = 1'b1;
        rx_valid = div_end && (bit_cnt == 3'd0);
      end
      LOAD: begin
        // The new MSB must appear in the consume cycle so sdi gets a full
        // CLK_DIV setup before the next rising edge.
        ss       = 1'b0;
        busy     = 1'b1;
        tx_ready = tx_valid;
        sdi      = tx_valid ? tx_data[7] : tx_sh[7];
      end
      GAP: begin
        busy = !gap_end;
        done = gap_end;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/dio_spi_master.md
# dio_spi_master

SPI initiator for the IO-controller link. It drives `ss`, `sck` and `sdi` and samples `sdo` with the same framing and bit order the FPGA-side data_io slave expects. One transaction is a command byte followed by a length-counted payload stream, framed by a single `ss` low period. It sits in the on-chip ROM/CMOS loader and in the system bench, in place of the arm7 IO controller. Typical use is replaying DIO_FILE_TX/TX_DAT/INDEX sequences or reading IDE/CMOS bytes back.

## Interface
- `CLK_DIV`, 4: sck half-period in `clk` cycles; minimum 2.
- `SS_GAP`, 8: minimum `clk` cycles `ss` stays high between transactions; minimum 1.
- `LEN_WIDTH`, 16: width of the payload length.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a transaction; accepted only while `busy`=0.
- `cmd`  in  8  command byte; latched on the accepted `start`.
- `len`  in  LEN_WIDTH  number of payload bytes after `cmd`; latched on start; 0 is legal.
- `tx_data`  in  8  next payload byte.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  one-cycle pulse; `tx_data` is consumed this cycle.
- `rx_data`  out  8  byte shifted in from `sdo`.
- `rx_valid`  out  1  one-cycle pulse per received byte, including the byte clocked during `cmd`.
- `busy`  out  1  high from the cycle after the accepted start until done.
- `done`  out  1  one-cycle pulse at transaction end.
- `ss`  out  1  chip select, active low.
- `sck`  out  1  serial clock; idles low.
- `sdi`  out  1  serial data to the slave, MSB first.
- `sdo`  in  1  serial data from the slave.

## Operation
- FSM states: IDLE, SETUP, LOW, HIGH, LOAD, HOLD, GAP.
- Reset and IDLE output values:
  - `ss`=1, `sck`=0, `sdi`=0.
  - `busy`=0, `done`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0.
  - Reset asserted mid-transaction returns every output to these values immediately. No partial byte is reported.
- IDLE: on `start`, latch `cmd`, `len` and the remaining-byte counter, then go to SETUP.
- SETUP: `ss`=0 and `sdi`=`cmd[7]` for CLK_DIV cycles, then go to HIGH.
- LOW: `sck`=0 for CLK_DIV cycles. `sdi` changes on the first cycle of LOW, i.e. coincident with the sck falling edge.
- HIGH: `sck`=1 for CLK_DIV cycles.
  - `sdo` is sampled into the shift register on the first cycle of HIGH.
  - After bit 0, the completed byte goes to `rx_data` and `rx_valid` pulses on the last cycle of HIGH.
- Byte boundary, reached at the end of HIGH after bit 0:
  - If the remaining count is 0, go to HOLD.
  - Otherwise go to LOAD.
- LOAD: `sck` stays low and `ss` stays low.
  - Wait for `tx_valid`.
  - On the cycle `tx_valid`=1: pulse `tx_ready`, latch `tx_data`, set `sdi` to its MSB, decrement the remaining count, and go to LOW for the remaining CLK_DIV−1 cycles of that low phase.
  - Underrun (`tx_valid` low) stretches the low phase with no bound and no spurious edges. This is legal because the slave is fully static.
- HOLD: `sck`=0 and `ss`=0 for CLK_DIV cycles, then set `ss`=1 and go to GAP.
- GAP: `ss`=1 for SS_GAP cycles. On the final cycle, pulse `done`, drop `busy` and return to IDLE.
- `start` while `busy` is ignored. `start` on the cycle `done` pulses is accepted, because `busy` is already 0 in that cycle.
- `len`=0: only the command byte is sent, and `tx_ready` never pulses.
- Bit counter is 3 bits and wraps 0→7 per byte. The remaining counter is LEN_WIDTH bits and never underflows, because it is checked for 0 before decrement.

## Timing
- `start` accepted at cycle 0; `ss` falls and `busy` rises at cycle 1.
- Transaction length with no underrun: 1 + CLK_DIV(SETUP) + (1+len)·8·2·CLK_DIV − CLK_DIV + CLK_DIV(HOLD) + SS_GAP cycles, from `start` to `done` inclusive.
- Each byte produces exactly 8 rising `sck` edges. There are exactly (1+len)·8 rising edges per transaction.
- `sdi` is stable for ≥CLK_DIV cycles on both sides of every rising `sck` edge.
- `rx_valid` latency: CLK_DIV−1 cycles after the 8th rising edge of the byte.

## Test plan
- CLK_DIV=2, `cmd`=0x55, `len`=1, `tx_data`=0x03 always valid:
  - 16 rising edges; `sdi` bits sampled at the edges read 01010101 00000011.
  - One `tx_ready` pulse; `done` after the computed cycle count; `ss` high ≥8 cycles afterwards.
- Behavioural data_io slave model returning 0xA5 for every byte, `len`=2: three `rx_valid` pulses, and `rx_data`=0xA5 on the 2nd and 3rd pulses.
- `len`=0, `cmd`=0x57: 8 rising edges, no `tx_ready`, `sck` low whenever `ss` changes.
- Underrun: hold `tx_valid` low for 20 cycles before byte 2 → `sck` low for ≥20 cycles with no extra edges, `ss` stays low, and the byte stream is intact.
- Pulse `start` during `busy` → ignored. Pulse `start` in the `done` cycle → second transaction begins, with `ss` falling on the next cycle.
- Deassert `rst_n` mid-byte → same cycle `ss`=1, `sck`=0, `busy`=0, no `rx_valid`. A new transaction after reset is correct.
